// File: rtl/axis_pkt_monitor.sv
// AXI-Stream packet monitor: counts packets and bytes, flags KEEP, stall and length protocol errors.
// Optional feature: define AXIS_MON_BACKPRESSURE_EN to drive stream_in_READY from a 16-bit LFSR.
module axis_pkt_monitor #(
    parameter int unsigned MAX_BEATS = 1024,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [63:0] stream_in_DATA,
    input  logic [7:0]  stream_in_KEEP,
    input  logic        stream_in_LAST,
    input  logic        stream_in_VALID,
    output logic        stream_in_READY,
    input  logic        clear,
    output logic [31:0] pkt_count,
    output logic [31:0] byte_count,
    output logic [15:0] last_pkt_bytes,
    output logic        pkt_done,
    output logic        err_keep,
    output logic        err_stall,
    output logic        err_len
);

    localparam int unsigned BEAT_W = $clog2(MAX_BEATS + 2);
    localparam int unsigned POP_W  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IN_PKT  = 2'd1,
        OVERLEN = 2'd2
    } state_t;

    if (MAX_BEATS == 0 || LFSR_SEED == 16'h0000) begin : g_param_check
        $error("axis_pkt_monitor: MAX_BEATS must be >= 1 and LFSR_SEED must be nonzero");
    end

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [15:0]         pbytes_q, pbytes_d;
    logic                ready_q;

    logic                accept;
    logic [POP_W-1:0]    keep_pop;
    logic                keep_contig;
    logic                keep_bad;
    logic [16:0]         pbytes_sum;
    logic                done_hit;
    logic                len_hit;

    logic                stall_q;
    logic [63:0]         hold_data_q;
    logic [7:0]          hold_keep_q;
    logic                hold_last_q;
    logic                stall_hit;

    logic [31:0]         pkt_base, byte_base;
    logic [32:0]         byte_sum;
    logic [31:0]         pkt_count_d, byte_count_d;
    logic [15:0]         last_pkt_bytes_d;
    logic                err_keep_d, err_stall_d, err_len_d;

    assign stream_in_READY = ready_q;
    assign accept          = stream_in_VALID & ready_q;

    // Ready generation: pseudo-random backpressure or always-ready.
`ifdef AXIS_MON_BACKPRESSURE_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q  <= LFSR_SEED;
            ready_q <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            ready_q <= lfsr_d[0];
        end
    end
`else
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end
`endif

    // KEEP decode: byte popcount and contiguity from bit 0.
    always_comb begin
        keep_pop = '0;
        for (int i = 0; i < 8; i++) begin
            keep_pop = keep_pop + POP_W'(stream_in_KEEP[i]);
        end
        keep_contig = (stream_in_KEEP != 8'h00) &&
                      ((stream_in_KEEP & (stream_in_KEEP + 8'd1)) == 8'h00);
        keep_bad    = stream_in_LAST ? !keep_contig : (stream_in_KEEP != 8'hFF);
    end

    // A held beat must stay stable and valid until it is accepted.
    assign stall_hit = stall_q & (~stream_in_VALID |
                                  (stream_in_DATA != hold_data_q) |
                                  (stream_in_KEEP != hold_keep_q) |
                                  (stream_in_LAST != hold_last_q));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_q     <= 1'b0;
            hold_data_q <= '0;
            hold_keep_q <= '0;
            hold_last_q <= 1'b0;
        end else begin
            stall_q     <= stream_in_VALID & ~ready_q;
            hold_data_q <= stream_in_DATA;
            hold_keep_q <= stream_in_KEEP;
            hold_last_q <= stream_in_LAST;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            pbytes_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            pbytes_q <= pbytes_d;
        end
    end

    // Packet FSM plus next values of every counter and flag.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        pbytes_d = pbytes_q;
        done_hit = 1'b0;
        len_hit  = 1'b0;

        pbytes_sum = {1'b0, pbytes_q} + 17'(keep_pop);

        if (accept) begin
            case (state_q)
                IDLE: begin
                    beat_d   = BEAT_W'(1);
                    pbytes_d = 16'(keep_pop);
                    if (stream_in_LAST) begin
                        done_hit = 1'b1;
                    end else begin
                        state_d = IN_PKT;
                    end
                end
                IN_PKT: begin
                    beat_d   = beat_q + BEAT_W'(1);
                    pbytes_d = pbytes_sum[16] ? 16'hFFFF : pbytes_sum[15:0];
                    if (stream_in_LAST) begin
                        done_hit = 1'b1;
                        state_d  = IDLE;
                    end else if (beat_q >= BEAT_W'(MAX_BEATS)) begin
                        len_hit = 1'b1;
                        state_d = OVERLEN;
                    end
                end
                OVERLEN: begin
                    pbytes_d = pbytes_sum[16] ? 16'hFFFF : pbytes_sum[15:0];
                    if (stream_in_LAST) begin
                        done_hit = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        pkt_base  = clear ? 32'd0 : pkt_count;
        byte_base = clear ? 32'd0 : byte_count;
        byte_sum  = {1'b0, byte_base} + 33'(keep_pop);

        pkt_count_d  = (done_hit && (pkt_base != 32'hFFFF_FFFF)) ? pkt_base + 32'd1 : pkt_base;
        byte_count_d = accept ? (byte_sum[32] ? 32'hFFFF_FFFF : byte_sum[31:0]) : byte_base;
        last_pkt_bytes_d = done_hit ? pbytes_d : last_pkt_bytes;

        err_keep_d  = (~clear & err_keep)  | (accept & keep_bad);
        err_stall_d = (~clear & err_stall) | stall_hit;
        err_len_d   = (~clear & err_len)   | len_hit;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pkt_count      <= '0;
            byte_count     <= '0;
            last_pkt_bytes <= '0;
            pkt_done       <= 1'b0;
            err_keep       <= 1'b0;
            err_stall      <= 1'b0;
            err_len        <= 1'b0;
        end else begin
            pkt_count      <= pkt_count_d;
            byte_count     <= byte_count_d;
            last_pkt_bytes <= last_pkt_bytes_d;
            pkt_done       <= done_hit;
            err_keep       <= err_keep_d;
            err_stall      <= err_stall_d;
            err_len        <= err_len_d;
        end
    end

endmodule

// File: tb/tb_axis_pkt_monitor.sv
// Bench for axis_pkt_monitor: packet-level reference model checked every cycle plus directed literal checks.
module tb_axis_pkt_monitor;

    localparam int unsigned MAX_BEATS = 4;
    localparam logic [15:0] SEED      = 16'hACE1;
    localparam longint      MAX32     = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        resetn;
    logic [63:0] stream_in_DATA;
    logic [7:0]  stream_in_KEEP;
    logic        stream_in_LAST;
    logic        stream_in_VALID;
    logic        stream_in_READY;
    logic        clear;
    logic [31:0] pkt_count;
    logic [31:0] byte_count;
    logic [15:0] last_pkt_bytes;
    logic        pkt_done;
    logic        err_keep;
    logic        err_stall;
    logic        err_len;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axis_pkt_monitor #(.MAX_BEATS(MAX_BEATS), .LFSR_SEED(SEED)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .stream_in_DATA (stream_in_DATA),
        .stream_in_KEEP (stream_in_KEEP),
        .stream_in_LAST (stream_in_LAST),
        .stream_in_VALID(stream_in_VALID),
        .stream_in_READY(stream_in_READY),
        .clear          (clear),
        .pkt_count      (pkt_count),
        .byte_count     (byte_count),
        .last_pkt_bytes (last_pkt_bytes),
        .pkt_done       (pkt_done),
        .err_keep       (err_keep),
        .err_stall      (err_stall),
        .err_len        (err_len)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: packet-level bookkeeping derived from the accept/LAST rules.
    bit          m_in_pkt, m_over;
    int          m_beats;
    longint      m_bytes;
    longint      e_pkt, e_byte, e_last;
    bit          e_done, e_ek, e_es, e_el, e_ready;
    bit          p_stall, p_last;
    logic [63:0] p_data;
    logic [7:0]  p_keep;
    logic [15:0] m_lfsr;
    int          done_seen = 0;

    always @(negedge clk) begin
        if (!resetn) begin
            m_in_pkt = 0; m_over = 0; m_beats = 0; m_bytes = 0;
            e_pkt = 0; e_byte = 0; e_last = 0;
            e_done = 0; e_ek = 0; e_es = 0; e_el = 0; e_ready = 0;
            p_stall = 0; p_data = '0; p_keep = '0; p_last = 0;
            m_lfsr = SEED;
        end
        chk("ready",          stream_in_READY, e_ready);
        chk("pkt_count",      pkt_count,       e_pkt);
        chk("byte_count",     byte_count,      e_byte);
        chk("last_pkt_bytes", last_pkt_bytes,  e_last);
        chk("pkt_done",       pkt_done,        e_done);
        chk("err_keep",       err_keep,        e_ek);
        chk("err_stall",      err_stall,       e_es);
        chk("err_len",        err_len,         e_el);
        if (pkt_done) done_seen++;

        if (resetn) begin
            bit acc, stall_now, contig;
            int pop;
            acc       = stream_in_VALID && e_ready;
            stall_now = p_stall && (!stream_in_VALID || stream_in_DATA != p_data ||
                                    stream_in_KEEP != p_keep || stream_in_LAST != p_last);
            p_stall = stream_in_VALID && !e_ready;
            p_data  = stream_in_DATA;
            p_keep  = stream_in_KEEP;
            p_last  = stream_in_LAST;

            if (clear) begin
                e_pkt = 0; e_byte = 0; e_ek = 0; e_es = 0; e_el = 0;
            end
            e_done = 0;
            if (acc) begin
                pop    = $countones(stream_in_KEEP);
                e_byte = (e_byte + pop > MAX32) ? MAX32 : e_byte + pop;
                if (!m_in_pkt) begin
                    m_beats = 1;
                    m_bytes = pop;
                end else begin
                    m_beats++;
                    m_bytes += pop;
                end
                contig = stream_in_KEEP inside {8'h01, 8'h03, 8'h07, 8'h0F,
                                                8'h1F, 8'h3F, 8'h7F, 8'hFF};
                if (stream_in_LAST ? !contig : (stream_in_KEEP != 8'hFF)) e_ek = 1;
                if (m_in_pkt && !m_over && !stream_in_LAST && m_beats > MAX_BEATS) begin
                    e_el   = 1;
                    m_over = 1;
                end
                if (stream_in_LAST) begin
                    e_done   = 1;
                    e_pkt    = (e_pkt + 1 > MAX32) ? MAX32 : e_pkt + 1;
                    e_last   = (m_bytes > 65535) ? 65535 : m_bytes;
                    m_in_pkt = 0;
                    m_over   = 0;
                end else begin
                    m_in_pkt = 1;
                end
            end
            if (stall_now) e_es = 1;
`ifdef AXIS_MON_BACKPRESSURE_EN
            m_lfsr  = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            e_ready = m_lfsr[0];
`else
            e_ready = 1;
`endif
        end
    end

    // Offer one beat and hold it until accepted; returns one step after the accepting edge.
    task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic c);
        bit acc;
        int n;
        acc = 0;
        n   = 0;
        stream_in_DATA  = d;
        stream_in_KEEP  = k;
        stream_in_LAST  = l;
        stream_in_VALID = 1'b1;
        clear           = c;
        do begin
            @(negedge clk);
            acc = stream_in_READY;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        chk("beat_accept", acc, 1);
        stream_in_VALID = 1'b0;
        clear           = 1'b0;
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

`ifdef AXIS_MON_BACKPRESSURE_EN
    // Present a beat during a READY=0 cycle, optionally change DATA while stalled.
    task automatic stall_run(input bit change, input logic exp_stall);
        int n;
        bit acc;
        n = 0;
        while (stream_in_READY && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("stall_ready_low", stream_in_READY, 0);
        stream_in_DATA  = 64'h1;
        stream_in_KEEP  = 8'hFF;
        stream_in_LAST  = 1'b1;
        stream_in_VALID = 1'b1;
        @(posedge clk);
        #1;
        if (change) stream_in_DATA = 64'h2;
        @(posedge clk);
        #1;
        chk("stall_flag", err_stall, exp_stall);
        acc = 0;
        n   = 0;
        do begin
            @(negedge clk);
            acc = stream_in_READY;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        chk("stall_accept", acc, 1);
        stream_in_VALID = 1'b0;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn          = 1'b0;
        stream_in_DATA  = '0;
        stream_in_KEEP  = '0;
        stream_in_LAST  = 1'b0;
        stream_in_VALID = 1'b0;
        clear           = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", stream_in_READY, 0);
        chk("rst_pkt",   pkt_count, 0);
        resetn = 1'b1;

        // Three 4-beat packets FF,FF,FF,0F.
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 4; i++) begin
                beat(64'(p * 4 + i), (i == 3) ? 8'h0F : 8'hFF, i == 3, 1'b0);
            end
        end
        @(posedge clk);
        #1;
        chk("three_pkt_count", pkt_count, 3);
        chk("three_byte_count", byte_count, 84);
        chk("three_last_bytes", last_pkt_bytes, 28);
        chk("three_done_pulses", done_seen, 3);
        chk("three_errors", {err_keep, err_stall, err_len}, 0);

        clear_pulse();
        chk("clear_pkt", pkt_count, 0);
        chk("clear_bytes", byte_count, 0);

        // Single beat with non-contiguous KEEP.
        beat(64'hA5, 8'h05, 1'b1, 1'b0);
        chk("keep05_err", err_keep, 1);
        chk("keep05_pkt", pkt_count, 1);
        chk("keep05_last", last_pkt_bytes, 2);
        clear_pulse();
        chk("clear_err_keep", err_keep, 0);

        // Six-beat packet against MAX_BEATS=4.
        for (int i = 0; i < 6; i++) begin
            beat(64'(i), 8'hFF, i == 5, 1'b0);
            if (i == 3) chk("len_after4", err_len, 0);
            if (i == 4) begin
                chk("len_after5", err_len, 1);
                chk("len_pkt_open", pkt_count, 0);
            end
        end
        chk("len_pkt_done", pkt_count, 1);
        chk("len_last_bytes", last_pkt_bytes, 48);
        beat(64'h7, 8'h03, 1'b1, 1'b0);
        chk("idle_again_pkt", pkt_count, 2);
        chk("idle_again_last", last_pkt_bytes, 2);

        // clear coincident with the LAST accept of a 2-beat packet.
        beat(64'h8, 8'hFF, 1'b0, 1'b0);
        beat(64'h9, 8'hFF, 1'b1, 1'b1);
        chk("clrlast_pkt", pkt_count, 1);
        chk("clrlast_bytes", byte_count, 8);
        chk("clrlast_errs", {err_keep, err_stall, err_len}, 0);
        chk("clrlast_last", last_pkt_bytes, 16);

        // Reset in mid-packet, then a fresh single-beat packet.
        beat(64'h10, 8'hFF, 1'b0, 1'b0);
        beat(64'h11, 8'hFF, 1'b0, 1'b0);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        beat(64'h12, 8'hFF, 1'b1, 1'b0);
        chk("rstmid_pkt", pkt_count, 1);
        chk("rstmid_last", last_pkt_bytes, 8);

        // clear with a KEEP error on the same accept keeps only the new error.
        beat(64'h13, 8'h0F, 1'b0, 1'b1);
        chk("clrerr_keep", err_keep, 1);
        chk("clrerr_bytes", byte_count, 4);
        chk("clrerr_pkt", pkt_count, 0);

`ifdef AXIS_MON_BACKPRESSURE_EN
        clear_pulse();
        stall_run(1'b1, 1'b1);
        clear_pulse();
        stall_run(1'b0, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_pkt_monitor.md
AXIS_PKT_MONITOR -- requirements
Module: axis_pkt_monitor

Interface
REQ-001 Parameter: MAX_BEATS, 1024, maximum beats per packet before the length error fires.
REQ-002 Parameter: LFSR_SEED, 16'hACE1, nonzero reset seed for the backpressure LFSR.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 stream_in_DATA  input  64  beat payload from the user-region output stream.
REQ-006 stream_in_KEEP  input  8  byte enables; bit i qualifies byte i.
REQ-007 stream_in_LAST  input  1  final beat of the packet.
REQ-008 stream_in_VALID  input  1  beat offered.
REQ-009 stream_in_READY  output  1  beat accepted when VALID and READY are both high.
REQ-010 clear  input  1  synchronous pulse that zeroes counters and sticky errors.
REQ-011 pkt_count  output  32  packets completed, saturating at 32'hFFFFFFFF.
REQ-012 byte_count  output  32  accepted bytes (popcount of KEEP), saturating.
REQ-013 last_pkt_bytes  output  16  byte length of the most recent completed packet.
REQ-014 pkt_done  output  1  one-cycle pulse per completed packet.
REQ-015 err_keep, err_stall, err_len  output  1 each  sticky protocol error flags.

Function
REQ-016 An accept occurs in any cycle where stream_in_VALID=1 and stream_in_READY=1; only accepts update counters or state.
REQ-017 FSM states and transitions:
- IDLE: accept with LAST=0 goes to IN_PKT; accept with LAST=1 completes a 1-beat packet and stays in IDLE.
- IN_PKT: accept with LAST=1 goes to IDLE; a non-LAST accept that would make the beat count exceed MAX_BEATS goes to OVERLEN.
- OVERLEN: accept with LAST=1 goes to IDLE.
REQ-018 Beat counter: reset to 1 on the first beat, incremented per accept; err_len sets on the cycle OVERLEN is entered.
REQ-019 Packet completion (accept with LAST=1, any state): pkt_done=1 in the following cycle, pkt_count increments, and last_pkt_bytes loads the running byte total including this beat, saturating at 16'hFFFF.
REQ-020 A packet that ends from OVERLEN still increments pkt_count and pulses pkt_done.
REQ-021 err_keep sets on an accept when either condition holds:
- LAST=0 and KEEP!=8'hFF;
- LAST=1 and KEEP is zero or not of the form 2^n-1 (contiguous from bit 0).
REQ-022 err_stall sets in cycle N+1 when cycle N had VALID=1 and READY=0 and cycle N+1 has VALID=0 or any change in DATA, KEEP or LAST.
REQ-023 byte_count adds popcount(KEEP) per accept, saturating.
REQ-024 Latency: all counter and flag updates are visible one cycle after the triggering accept.
REQ-025 clear combined with an accept in the same cycle: counters load only that cycle's contribution; errors load only that cycle's detections. The FSM is not affected by clear.
REQ-026 Counter values held at saturation do not wrap.

Reset
REQ-027 While resetn=0, the following hold: stream_in_READY=0, FSM=IDLE, all counters 0, last_pkt_bytes=0, pkt_done=0, all error flags 0, LFSR=LFSR_SEED, stall history cleared.
REQ-028 Reset mid-packet discards the partial packet; after resetn deasserts, the first accept is treated as a packet start.
REQ-029 stream_in_READY first asserts no earlier than the first clk edge after resetn deasserts.

Configuration
REQ-030 With macro AXIS_MON_BACKPRESSURE_EN defined:
- stream_in_READY equals bit 0 of a 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every cycle out of reset;
- the 16'h0000 state is unreachable.
REQ-031 Without AXIS_MON_BACKPRESSURE_EN, stream_in_READY is 1 in every cycle after reset and no LFSR is instantiated.

Verification
REQ-032 Three packets of 4 beats each (KEEP=FF,FF,FF,0F), READY high:
- pkt_count=3, byte_count=84, last_pkt_bytes=28;
- exactly 3 pkt_done pulses;
- no errors.
REQ-033 Single beat with LAST=1, KEEP=8'h05: err_keep=1, pkt_count=1, last_pkt_bytes=2.
REQ-034 With AXIS_MON_BACKPRESSURE_EN, VALID held while READY=0 but DATA changed from 0x1 to 0x2: err_stall=1 the next cycle. A repeat run with DATA held: err_stall=0.
REQ-035 MAX_BEATS=4 and a 6-beat packet:
- err_len=1 after the 5th beat accept;
- pkt_count=1 after LAST;
- FSM returns to IDLE.
REQ-036 clear asserted on the same cycle as the LAST accept of a 2-beat FF/FF packet: pkt_count=1, byte_count=8, errors=0.
REQ-037 resetn pulsed low after 2 beats of a packet, then a fresh 1-beat LAST packet with KEEP=FF: pkt_count=1, last_pkt_bytes=8.
